// File: rtl/period_tick_gen.sv
// Periodic tick generator: loads a period, ticks once per period, and can shorten the period at boundaries.
// Optional macro PERIOD_MIN_CLAMP_EN raises the period floor from 1 to MIN_PERIOD.
//
// state | meaning
// IDLE  | stopped, count held at 0, no ticks
// LOAD  | one cycle: fetch base_period into cur_period, clear count
// RUN   | counting; boundary when count == cur_period-1, tick registered on it
module period_tick_gen #(
  parameter int N          = 8,
  parameter int MIN_PERIOD = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         enable,
  input  logic         reload,
  input  logic         modify_period,
  input  logic [N-1:0] base_period,
  input  logic [N-1:0] step,
  output logic         tick,
  output logic [N-1:0] cur_period,
  output logic         at_floor
);

`ifdef PERIOD_MIN_CLAMP_EN
  localparam logic [N-1:0] FLOOR = N'(MIN_PERIOD);
`else
  // MIN_PERIOD has no effect without the clamp; the floor is fixed at 1.
  localparam logic [N-1:0] FLOOR = N'(1 + 0 * MIN_PERIOD);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] count, count_nxt;
  logic [N-1:0] period_nxt;
  logic [N-1:0] load_val;
  logic [N-1:0] shortened;
  logic [N:0]   diff;
  logic         tick_nxt;
  logic         boundary;

  // Extra MSB on the subtraction catches underflow, which saturates to the floor.
  always_comb begin
    diff = {1'b0, cur_period} - {1'b0, step};
    if (diff[N] || (diff[N-1:0] < FLOOR)) shortened = FLOOR;
    else                                   shortened = diff[N-1:0];
  end

  assign load_val = (base_period < FLOOR) ? FLOOR : base_period;
  assign boundary = (count == (cur_period - N'(1)));
  assign at_floor = (cur_period == FLOOR);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    period_nxt = cur_period;
    tick_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        count_nxt = '0;
        if (enable) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = '0;
        if (!enable) begin
          state_nxt = S_IDLE;
        end else begin
          period_nxt = load_val;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end else if (reload) begin
          state_nxt = S_LOAD;
          count_nxt = '0;
        end else if (boundary) begin
          count_nxt = '0;
          tick_nxt  = 1'b1;
          if (modify_period) period_nxt = shortened;
        end else begin
          count_nxt = count + N'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      count      <= '0;
      tick       <= 1'b0;
      cur_period <= '1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      tick       <= tick_nxt;
      cur_period <= period_nxt;
    end
  end

endmodule

// File: tb/tb_period_tick_gen.sv
// Self-checking bench for period_tick_gen; reference model tracks absolute boundary times.
// Honours PERIOD_MIN_CLAMP_EN the same way as the design.
module tb_period_tick_gen;
  localparam int N          = 8;
  localparam int MIN_PERIOD = 4;
`ifdef PERIOD_MIN_CLAMP_EN
  localparam int FLOOR = MIN_PERIOD;
`else
  localparam int FLOOR = 1;
`endif

  logic         clk = 1'b0;
  logic         n_reset;
  logic         enable;
  logic         reload;
  logic         modify_period;
  logic [N-1:0] base_period;
  logic [N-1:0] step;
  logic         tick;
  logic [N-1:0] cur_period;
  logic         at_floor;

  int n_compared   = 0;
  int n_mismatched = 0;

  // model: mode 0 idle / 1 load / 2 run; boundaries kept as absolute cycle numbers
  int m_mode     = 0;
  int m_cyc      = 0;
  int m_next_bnd = 0;
  int m_period   = (1 << N) - 1;
  bit m_tick     = 1'b0;

  period_tick_gen #(.N(N), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enable       (enable),
    .reload       (reload),
    .modify_period(modify_period),
    .base_period  (base_period),
    .step         (step),
    .tick         (tick),
    .cur_period   (cur_period),
    .at_floor     (at_floor)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode   = 0;
    m_period = (1 << N) - 1;
    m_tick   = 1'b0;
  endtask

  task automatic model_step();
    bit nt;
    nt = 1'b0;
    case (m_mode)
      0: if (enable) m_mode = 1;
      1: begin
        if (!enable) m_mode = 0;
        else begin
          m_period   = (int'(base_period) < FLOOR) ? FLOOR : int'(base_period);
          m_next_bnd = m_cyc + m_period;
          m_mode     = 2;
        end
      end
      default: begin
        if (!enable) m_mode = 0;
        else if (reload) m_mode = 1;
        else if (m_cyc == m_next_bnd) begin
          nt = 1'b1;
          if (modify_period) begin
            m_period = m_period - int'(step);
            if (m_period < FLOOR) m_period = FLOOR;
          end
          m_next_bnd = m_cyc + m_period;
        end
      end
    endcase
    m_tick = nt;
    m_cyc++;
  endtask

  // called at a negedge; returns at the next negedge with outputs settled
  task automatic run_cycle(input logic en, input logic rl, input logic md,
                           input logic [N-1:0] b, input logic [N-1:0] s);
    enable        = en;
    reload        = rl;
    modify_period = md;
    base_period   = b;
    step          = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    enable = 1'b0; reload = 1'b0; modify_period = 1'b0;
    base_period = '0; step = '0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (tick !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_tick: got %b expected 0", tick);
    end
    n_compared++;
    if (cur_period !== 8'hFF) begin
      n_mismatched++; $display("FAIL reset_period: got %0h expected ff", cur_period);
    end
    n_compared++;
    if (at_floor !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_at_floor: got %b expected 0", at_floor);
    end
    n_reset = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic exp_t;
    for (int k = 0; k < 18; k++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd5, 8'd0);
      exp_t = (k == 6 || k == 11 || k == 16);
      n_compared++;
      if (tick !== exp_t) begin
        n_mismatched++; $display("FAIL basic_tick k=%0d: got %b expected %b", k, tick, exp_t);
      end
    end
    n_compared++;
    if (cur_period !== 8'd5) begin
      n_mismatched++; $display("FAIL basic_period: got %0d expected 5", cur_period);
    end
    go_idle();
  endtask

  task automatic test_modify();
    int seq[$];
    int exp_seq[$];
`ifdef PERIOD_MIN_CLAMP_EN
    exp_seq = '{10, 7, 4};
`else
    exp_seq = '{10, 7, 4, 1};
`endif
    for (int k = 0; k < 60; k++) begin
      run_cycle(1'b1, 1'b0, 1'b1, 8'd10, 8'd3);
      n_compared++;
      if (tick !== m_tick || cur_period !== N'(m_period)) begin
        n_mismatched++;
        $display("FAIL modify_cycle k=%0d: got tick=%b period=%0d expected tick=%b period=%0d",
                 k, tick, cur_period, m_tick, m_period);
      end
      if (k >= 1 && (seq.size() == 0 || seq[$] != int'(cur_period))) seq.push_back(int'(cur_period));
    end
    n_compared++;
    if (seq != exp_seq) begin
      n_mismatched++;
      $display("FAIL modify_sequence: got %p expected %p", seq, exp_seq);
    end
    n_compared++;
    if (at_floor !== 1'b1 || cur_period !== N'(FLOOR)) begin
      n_mismatched++;
      $display("FAIL modify_floor: got at_floor=%b period=%0d expected 1 and %0d", at_floor, cur_period, FLOOR);
    end
    go_idle();
  endtask

  task automatic test_step_zero();
    for (int k = 0; k < 25; k++) begin
      run_cycle(1'b1, 1'b0, 1'b1, 8'd6, 8'd0);
      n_compared++;
      if (tick !== m_tick) begin
        n_mismatched++; $display("FAIL step_zero_tick k=%0d: got %b expected %b", k, tick, m_tick);
      end
    end
    n_compared++;
    if (cur_period !== 8'd6) begin
      n_mismatched++; $display("FAIL step_zero_period: got %0d expected 6", cur_period);
    end
    go_idle();
  endtask

  task automatic test_offboundary();
    int ticks[$];
    int exp_ticks[$];
    exp_ticks = '{9, 17, 25, 33};
    for (int k = 0; k < 36; k++) begin
      run_cycle(1'b1, 1'b0, (k == 5), 8'd8, 8'd3);
      if (tick === 1'b1) ticks.push_back(k);
    end
    n_compared++;
    if (ticks != exp_ticks) begin
      n_mismatched++; $display("FAIL offboundary_ticks: got %p expected %p", ticks, exp_ticks);
    end
    n_compared++;
    if (cur_period !== 8'd8) begin
      n_mismatched++; $display("FAIL offboundary_period: got %0d expected 8", cur_period);
    end
    go_idle();
  endtask

  task automatic test_enable_drop();
    bit found;
    int first;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_mode == 2 && m_cyc == m_next_bnd) begin
        run_cycle(1'b0, 1'b0, 1'b1, 8'd6, 8'd2);
        found = 1'b1;
      end else begin
        run_cycle(1'b1, 1'b0, 1'b0, 8'd6, 8'd2);
      end
    end
    n_compared++;
    if (!found) begin
      n_mismatched++; $display("FAIL drop_timeout: got no boundary expected one within 40 cycles");
    end
    n_compared++;
    if (tick !== 1'b0 || cur_period !== 8'd6) begin
      n_mismatched++;
      $display("FAIL drop_boundary: got tick=%b period=%0d expected tick=0 period=6", tick, cur_period);
    end
    first = -1;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd7, 8'd0);
      if (tick === 1'b1 && first < 0) first = k;
    end
    n_compared++;
    if (first != 8) begin
      n_mismatched++; $display("FAIL drop_restart: got first tick at %0d expected 8", first);
    end
    go_idle();
  endtask

  task automatic test_reload();
    int guard;
    int first;
    guard = 0;
    run_cycle(1'b1, 1'b0, 1'b1, 8'd10, 8'd3);
    while (!(m_mode == 2 && m_period == 4) && guard < 80) begin
      run_cycle(1'b1, 1'b0, 1'b1, 8'd10, 8'd3);
      guard++;
    end
    n_compared++;
    if (cur_period !== 8'd4) begin
      n_mismatched++; $display("FAIL reload_reach4: got %0d expected 4", cur_period);
    end
    run_cycle(1'b1, 1'b0, 1'b0, 8'd10, 8'd3);
    guard = 0;
    while (m_cyc == m_next_bnd && guard < 10) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd10, 8'd3);
      guard++;
    end
    run_cycle(1'b1, 1'b1, 1'b0, 8'd9, 8'd3);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd9, 8'd3);
      if (tick === 1'b1 && first < 0) first = i;
    end
    n_compared++;
    if (first != 10) begin
      n_mismatched++; $display("FAIL reload_latency: got %0d expected 10", first);
    end
    n_compared++;
    if (cur_period !== 8'd9) begin
      n_mismatched++; $display("FAIL reload_period: got %0d expected 9", cur_period);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd8, 8'd0);
      if (tick === 1'b1) seen = 1'b1;
    end
    n_compared++;
    if (!seen) begin
      n_mismatched++; $display("FAIL reset_mid_timeout: got no tick expected one within 30 cycles");
    end
    n_reset = 1'b0;
    #1;
    model_reset();
    n_compared++;
    if (tick !== 1'b0 || cur_period !== 8'hFF || at_floor !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_mid_async: got tick=%b period=%0h at_floor=%b expected 0 ff 0", tick, cur_period, at_floor);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (tick !== 1'b0 || cur_period !== 8'hFF) begin
      n_mismatched++; $display("FAIL reset_mid_hold: got tick=%b period=%0h expected 0 ff", tick, cur_period);
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      n_compared++;
      if (tick !== m_tick) begin
        n_mismatched++; $display("FAIL reset_mid_tick k=%0d: got %b expected %b", k, tick, m_tick);
      end
    end
    n_compared++;
    if (cur_period !== N'(FLOOR) || at_floor !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_mid_zero_load: got period=%0d at_floor=%b expected %0d and 1", cur_period, at_floor, FLOOR);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic         en, rl, md;
    logic [N-1:0] b, s;
    b = 8'd6;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 999) < 3) begin
        n_reset = 1'b0;
        #1;
        model_reset();
        n_compared++;
        if (tick !== 1'b0 || cur_period !== 8'hFF) begin
          n_mismatched++; $display("FAIL rand_reset k=%0d: got tick=%b period=%0h expected 0 ff", k, tick, cur_period);
        end
        @(negedge clk);
        n_reset = 1'b1;
      end
      en = ($urandom_range(0, 99) < 95);
      rl = ($urandom_range(0, 99) < 3);
      md = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 5) b = N'($urandom_range(0, 20));
      s = N'($urandom_range(0, 5));
      run_cycle(en, rl, md, b, s);
      n_compared++;
      if (tick !== m_tick) begin
        n_mismatched++; $display("FAIL rand_tick k=%0d: got %b expected %b", k, tick, m_tick);
      end
      n_compared++;
      if (cur_period !== N'(m_period)) begin
        n_mismatched++; $display("FAIL rand_period k=%0d: got %0d expected %0d", k, cur_period, m_period);
      end
      n_compared++;
      if (at_floor !== (m_period == FLOOR)) begin
        n_mismatched++; $display("FAIL rand_at_floor k=%0d: got %b expected %b", k, at_floor, (m_period == FLOOR));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modify();
    test_step_zero();
    test_offboundary();
    test_enable_drop();
    test_reload();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
